// File: rtl/seven_seg_arbiter.sv
// Shares a 4-digit multiplexed 7-segment display between NUM_REQ requesters.
// Round-robin ownership with a minimum hold, switched and snapshotted only at frame boundaries.
module seven_seg_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int DIV_RATIO   = 100000,
    parameter int HOLD_FRAMES = 250
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [16*NUM_REQ-1:0]  data,
    input  logic [4*NUM_REQ-1:0]   dp,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   frame_tick,
    output logic [7:0]             seg,
    output logic [3:0]             an
);
    localparam int SW  = (DIV_RATIO > 1) ? $clog2(DIV_RATIO) : 1;
    localparam int HW  = $clog2(HOLD_FRAMES + 1);
    localparam int PW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW1 = PW + 1;
    localparam logic [SW-1:0] SLOT_LAST = SW'(DIV_RATIO - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_FRAMES - 1);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_OWNED = 1'b1} state_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] pat;
        case (nib)
            4'h0: pat = 7'b1000000;
            4'h1: pat = 7'b1111001;
            4'h2: pat = 7'b0100100;
            4'h3: pat = 7'b0110000;
            4'h4: pat = 7'b0011001;
            4'h5: pat = 7'b0010010;
            4'h6: pat = 7'b0000010;
            4'h7: pat = 7'b1111000;
            4'h8: pat = 7'b0000000;
            4'h9: pat = 7'b0010000;
            4'hA: pat = 7'b0001000;
            4'hB: pat = 7'b0000011;
            4'hC: pat = 7'b1000110;
            4'hD: pat = 7'b0100001;
            4'hE: pat = 7'b0000110;
            4'hF: pat = 7'b0001110;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    // First asserted request among 'span' requesters starting at 'start'; MSB = found.
    function automatic logic [PW:0] find_req(input logic [NUM_REQ-1:0] req_v,
                                             input logic [PW-1:0] start, input int span);
        logic [PW:0]  res;
        logic [PW1-1:0] idx;
        res = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, start} + PW1'(k);
            idx = (idx >= PW1'(NUM_REQ)) ? idx - PW1'(NUM_REQ) : idx;
            res = ((k < span) && req_v[idx[PW-1:0]]) ? {1'b1, idx[PW-1:0]} : res;
        end
        return res;
    endfunction

    logic [SW-1:0]      r_slot_cnt;
    logic [1:0]         r_digit_idx;
    logic               r_frame_tick;
    state_t             r_state;
    logic [PW-1:0]      r_owner;
    logic [PW-1:0]      r_rr_ptr;
    logic [HW-1:0]      r_hold_cnt;
    logic [15:0]        r_buf_data;
    logic [3:0]         r_buf_dp;
    logic               r_buf_valid;
    logic [NUM_REQ-1:0] r_grant;
    logic [7:0]         r_seg;
    logic [3:0]         r_an;

    logic               w_slot_wrap;
    logic               w_frame_end;
    logic [PW:0]        w_pick_idle;
    logic [PW:0]        w_pick_other;
    logic               w_owner_req;
    state_t             w_next_state;
    logic [PW-1:0]      w_next_owner;
    logic [PW-1:0]      w_next_ptr;
    logic [HW-1:0]      w_next_hold;
    logic               w_change;
    logic [15:0]        w_snap_data;
    logic [3:0]         w_snap_dp;
    logic [NUM_REQ-1:0] w_owner_onehot;
    logic [3:0]         w_nibble;

    assign w_slot_wrap  = (r_slot_cnt == SLOT_LAST);
    assign w_frame_end  = w_slot_wrap && (r_digit_idx == 2'd3);
    // While owned the RR pointer sits at owner+1, so NUM_REQ-1 slots from it are exactly the others.
    assign w_pick_idle  = find_req(req, r_rr_ptr, NUM_REQ);
    assign w_pick_other = find_req(req, r_rr_ptr, NUM_REQ - 1);
    assign w_owner_req  = req[r_owner];

    // Arbitration next-state, evaluated for use at frame_end only
    always_comb begin
        w_next_state = r_state;
        w_next_owner = r_owner;
        w_next_hold  = r_hold_cnt;
        w_next_ptr   = r_rr_ptr;
        w_change     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_idle[PW]) begin
                    w_next_state = ST_OWNED;
                    w_next_owner = w_pick_idle[PW-1:0];
                    w_change     = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_OWNED: begin
                if (!w_owner_req) begin
                    if (w_pick_other[PW]) begin
                        w_next_owner = w_pick_other[PW-1:0];
                        w_change     = 1'b1;
                    end else begin
                        w_next_state = ST_IDLE;
                        w_next_hold  = '0;
                    end
                end else if (w_pick_other[PW] && (r_hold_cnt == HOLD_LAST)) begin
                    w_next_owner = w_pick_other[PW-1:0];
                    w_change     = 1'b1;
                end else begin
                    w_next_hold = (r_hold_cnt == HOLD_LAST) ? r_hold_cnt : r_hold_cnt + HW'(1);
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
        if (w_change) begin
            w_next_hold = '0;
            w_next_ptr  = (w_next_owner == PW'(NUM_REQ - 1)) ? '0 : w_next_owner + PW'(1);
        end else begin
            w_next_ptr = r_rr_ptr;
        end
    end

    // Snapshot mux and one-hot grant decode
    always_comb begin
        w_snap_data    = 16'h0000;
        w_snap_dp      = 4'h0;
        w_owner_onehot = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_snap_data       = (w_next_owner == PW'(i)) ? data[16*i +: 16] : w_snap_data;
            w_snap_dp         = (w_next_owner == PW'(i)) ? dp[4*i +: 4] : w_snap_dp;
            w_owner_onehot[i] = (r_state == ST_OWNED) && (r_owner == PW'(i));
        end
    end

    // Nibble of the digit currently being scanned
    always_comb begin
        case (r_digit_idx)
            2'd0:    w_nibble = r_buf_data[3:0];
            2'd1:    w_nibble = r_buf_data[7:4];
            2'd2:    w_nibble = r_buf_data[11:8];
            2'd3:    w_nibble = r_buf_data[15:12];
            default: w_nibble = 4'h0;
        endcase
    end

    // Slot/digit timebase and frame tick
    always_ff @(posedge clk) begin
        if (reset) begin
            r_slot_cnt   <= '0;
            r_digit_idx  <= 2'd0;
            r_frame_tick <= 1'b0;
        end else begin
            r_slot_cnt   <= w_slot_wrap ? '0 : r_slot_cnt + SW'(1);
            r_digit_idx  <= w_slot_wrap ? r_digit_idx + 2'd1 : r_digit_idx;
            r_frame_tick <= w_frame_end;
        end
    end

    // Ownership state and display buffer, both change only at frame boundaries
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_owner     <= '0;
            r_rr_ptr    <= '0;
            r_hold_cnt  <= '0;
            r_buf_data  <= 16'h0000;
            r_buf_dp    <= 4'h0;
            r_buf_valid <= 1'b0;
        end else if (w_frame_end) begin
            r_state     <= w_next_state;
            r_owner     <= w_next_owner;
            r_rr_ptr    <= w_next_ptr;
            r_hold_cnt  <= w_next_hold;
            r_buf_data  <= (w_next_state == ST_OWNED) ? w_snap_data : 16'h0000;
            r_buf_dp    <= (w_next_state == ST_OWNED) ? w_snap_dp : 4'h0;
            r_buf_valid <= (w_next_state == ST_OWNED);
        end else begin
            r_state     <= r_state;
            r_buf_valid <= r_buf_valid;
        end
    end

    // Pin drivers; grant lags the FSM by one cycle so it lines up with digit 0 on the pins
    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant <= '0;
            r_an    <= 4'hF;
            r_seg   <= 8'hFF;
        end else begin
            r_grant <= w_owner_onehot;
            r_an    <= r_buf_valid ? ~(4'b0001 << r_digit_idx) : 4'hF;
            r_seg   <= r_buf_valid ? {~r_buf_dp[r_digit_idx], hex_to_seg(w_nibble)} : 8'hFF;
        end
    end

    assign grant      = r_grant;
    assign frame_tick = r_frame_tick;
    assign seg        = r_seg;
    assign an         = r_an;
endmodule

// File: tb/tb_seven_seg_arbiter.sv
// Self-checking bench for seven_seg_arbiter: directed scenarios plus random traffic,
// compared against a frame-level reference model built on a cycle count since reset.
module tb_seven_seg_arbiter;
    localparam int N     = 2;
    localparam int DIV   = 4;
    localparam int HOLD  = 2;
    localparam int FRAME = 4 * DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [31:0] data = 32'h0;
    logic [7:0]  dp = 8'h0;
    logic [1:0]  grant;
    logic        frame_tick;
    logic [7:0]  seg;
    logic [3:0]  an;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                 7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    seven_seg_arbiter #(.NUM_REQ(N), .DIV_RATIO(DIV), .HOLD_FRAMES(HOLD)) dut (
        .clk(clk), .reset(reset), .req(req), .data(data), .dp(dp),
        .grant(grant), .frame_tick(frame_tick), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    // Reference model: p = edges since reset; boundaries every FRAME edges; outputs lag one edge.
    int m_p, m_owner, m_ptr, m_frames;
    logic [15:0] m_sdata;
    logic [3:0]  m_sdp;
    logic        m_svalid;
    logic [1:0]  e_grant;
    logic [3:0]  e_an;
    logic [7:0]  e_seg;
    logic        e_tick;

    initial begin : model
        int nxt, other, c, d;
        m_p = 0; m_owner = -1; m_ptr = 0; m_frames = 0;
        m_sdata = 16'h0; m_sdp = 4'h0; m_svalid = 1'b0;
        e_grant = 2'b00; e_an = 4'hF; e_seg = 8'hFF; e_tick = 1'b0;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_p = 0; m_owner = -1; m_ptr = 0; m_frames = 0; m_svalid = 1'b0;
                e_grant = 2'b00; e_an = 4'hF; e_seg = 8'hFF; e_tick = 1'b0;
            end else begin
                m_p = m_p + 1;
                e_grant = (m_owner < 0) ? 2'b00 : 2'(1 << m_owner);
                if (m_svalid) begin
                    d = ((m_p - 1) / DIV) % 4;
                    e_an = 4'hF ^ 4'(1 << d);
                    e_seg = {~m_sdp[d], hex_tab[m_sdata[4*d +: 4]]};
                end else begin
                    e_an = 4'hF; e_seg = 8'hFF;
                end
                e_tick = (m_p % FRAME == 0);
                if (m_p % FRAME == 0) begin
                    nxt = -1;
                    if (m_owner < 0) begin
                        for (int k = 0; k < N; k++) begin
                            c = (m_ptr + k) % N;
                            if (nxt < 0 && req[c]) nxt = c;
                        end
                    end else begin
                        other = -1;
                        for (int k = 1; k < N; k++) begin
                            c = (m_owner + k) % N;
                            if (other < 0 && req[c]) other = c;
                        end
                        if (!req[m_owner]) nxt = other;
                        else if (other >= 0 && m_frames >= HOLD) nxt = other;
                        else nxt = m_owner;
                    end
                    if (nxt != m_owner) begin
                        if (nxt >= 0) begin m_ptr = (nxt + 1) % N; m_frames = 1; end
                        m_owner = nxt;
                    end else if (nxt >= 0) begin
                        m_frames = m_frames + 1;
                    end
                    m_svalid = (m_owner >= 0);
                    if (m_owner >= 0) begin
                        m_sdata = data[16*m_owner +: 16];
                        m_sdp = dp[4*m_owner +: 4];
                    end
                end
            end
        end
    end

    task automatic test_reset();
        int ticks, last_tick;
        req = 2'b00;
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({grant, an, seg, frame_tick} !== {2'b00, 4'hF, 8'hFF, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state grant=%b an=%h seg=%h tick=%b, wanted 00 f ff 0", grant, an, seg, frame_tick);
        end
        reset = 1'b0;
        ticks = 0; last_tick = 0;
        for (int i = 1; i <= 3 * FRAME; i++) begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin ticks++; last_tick = i; end
            n_checks++;
            if ({grant, an, seg, frame_tick} !== {e_grant, e_an, e_seg, e_tick}) begin
                n_fail++;
                $display("FAIL idle_model cyc=%0d got %b/%h/%h/%b want %b/%h/%h/%b", i, grant, an, seg, frame_tick, e_grant, e_an, e_seg, e_tick);
            end
        end
        n_checks++;
        if (ticks != 3 || last_tick != 3 * FRAME) begin
            n_fail++;
            $display("FAIL tick_period got %0d ticks last at %0d, wanted 3 ticks last at %0d", ticks, last_tick, 3 * FRAME);
        end
    endtask

    task automatic test_single_owner();
        logic [3:0] an_exp [4];
        logic [3:0] dig_exp [4];
        logic [7:0] seg_exp;
        an_exp = '{4'hE, 4'hD, 4'hB, 4'h7};
        dig_exp = '{4'h4, 4'h3, 4'h2, 4'h1};
        data = {$urandom, 16'h1234} ; data[15:0] = 16'h1234;
        dp = {4'($urandom), 4'b0010};
        req = 2'b01;
        for (int w = 0; w < 3 * FRAME && grant == 2'b00; w++) @(negedge clk);
        n_checks++;
        if (grant !== 2'b01) begin n_fail++; $display("FAIL single_grant got %b want 01", grant); end
        for (int i = 0; i < FRAME; i++) begin
            if (i > 0) @(negedge clk);
            seg_exp = {(i / DIV == 1) ? 1'b0 : 1'b1, hex_tab[dig_exp[i / DIV]]};
            n_checks++;
            if (an !== an_exp[i / DIV] || seg !== seg_exp) begin
                n_fail++;
                $display("FAIL single_scan i=%0d an=%h seg=%h want an=%h seg=%h", i, an, seg, an_exp[i / DIV], seg_exp);
            end
        end
    endtask

    task automatic test_rr_alternate();
        logic [1:0] g_exp;
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        data = {$urandom, $urandom} ; dp = 8'($urandom);
        req = 2'b11;
        for (int w = 0; w < 3 * FRAME && grant == 2'b00; w++) @(negedge clk);
        for (int f = 0; f < 8; f++) begin
            g_exp = ((f / HOLD) % 2 == 0) ? 2'b01 : 2'b10;
            n_checks++;
            if (grant !== g_exp) begin n_fail++; $display("FAIL rr_frame f=%0d got %b want %b", f, grant, g_exp); end
            for (int i = 0; i < FRAME; i++) begin
                @(negedge clk);
                n_checks++;
                if ({grant, an, seg, frame_tick} !== {e_grant, e_an, e_seg, e_tick}) begin
                    n_fail++;
                    $display("FAIL rr_model f=%0d i=%0d got %b/%h/%h want %b/%h/%h", f, i, grant, an, seg, e_grant, e_an, e_seg);
                end
            end
        end
    endtask

    task automatic test_owner_drop();
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        req = 2'b11;
        for (int w = 0; w < 3 * FRAME && grant == 2'b00; w++) @(negedge clk);
        n_checks++;
        if (grant !== 2'b01) begin n_fail++; $display("FAIL drop_first got %b want 01", grant); end
        for (int i = 0; i < FRAME; i++) begin
            @(negedge clk);
            if (i == FRAME / 2 - 1) req = 2'b10;
            n_checks++;
            if ({grant, an, seg, frame_tick} !== {e_grant, e_an, e_seg, e_tick}) begin
                n_fail++;
                $display("FAIL drop_model i=%0d got %b/%h/%h want %b/%h/%h", i, grant, an, seg, e_grant, e_an, e_seg);
            end
        end
        n_checks++;
        if (grant !== 2'b10) begin n_fail++; $display("FAIL drop_switch got %b want 10", grant); end
    endtask

    task automatic test_snapshot();
        logic [15:0] val;
        logic [7:0]  seg_exp;
        int d;
        @(negedge clk) reset = 1'b1;
        @(negedge clk) reset = 1'b0;
        data[15:0] = 16'h1234; dp[3:0] = 4'b0000;
        req = 2'b01;
        for (int w = 0; w < 3 * FRAME && grant == 2'b00; w++) @(negedge clk);
        for (int i = 0; i < 2 * FRAME; i++) begin
            if (i > 0) @(negedge clk);
            if (i == 5) data[15:0] = 16'h5678;
            val = (i < FRAME) ? 16'h1234 : 16'h5678;
            d = (i / DIV) % 4;
            seg_exp = {1'b1, hex_tab[val[4*d +: 4]]};
            n_checks++;
            if (seg !== seg_exp || an !== (4'hF ^ 4'(1 << d))) begin
                n_fail++;
                $display("FAIL snapshot i=%0d seg=%h an=%h want seg=%h digit %0d", i, seg, an, seg_exp, d);
            end
        end
    endtask

    task automatic test_reset_mid();
        req = 2'b11;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({grant, an, seg, frame_tick} !== {2'b00, 4'hF, 8'hFF, 1'b0}) begin
            n_fail++;
            $display("FAIL midreset_state grant=%b an=%h seg=%h tick=%b, wanted 00 f ff 0", grant, an, seg, frame_tick);
        end
        reset = 1'b0;
        for (int w = 0; w < 3 * FRAME && grant == 2'b00; w++) @(negedge clk);
        n_checks++;
        if (grant !== 2'b01) begin n_fail++; $display("FAIL midreset_first got %b want 01", grant); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 24 * FRAME; i++) begin
            @(negedge clk);
            n_checks++;
            if ({grant, an, seg, frame_tick} !== {e_grant, e_an, e_seg, e_tick}) begin
                n_fail++;
                $display("FAIL rand_model i=%0d got %b/%h/%h/%b want %b/%h/%h/%b", i, grant, an, seg, frame_tick, e_grant, e_an, e_seg, e_tick);
            end
            if ($urandom_range(0, 11) == 0) req = 2'($urandom);
            if ($urandom_range(0, 5) == 0) begin data = $urandom; dp = 8'($urandom); end
        end
    endtask

    initial begin
        repeat (2) @(negedge clk);
        test_reset();
        test_single_owner();
        test_rr_alternate();
        test_owner_drop();
        test_snapshot();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
